// File: rtl/sequence_generator.sv
// Serial frame transmitter: sync pattern, payload MSB-first, then a fixed idle gap.
// One frame per payload word accepted over a valid/ready handshake.
module sequence_generator #(
    parameter int                  SYNC_LEN     = 6,
    parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 6'b110101,
    parameter int                  DATA_W       = 8,
    parameter int                  GAP_CYCLES   = 2,
    parameter logic                IDLE_BIT     = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] payload_in,
    input  logic              payload_valid,
    output logic              payload_ready,
    output logic              data_out,
    output logic              sync_active,
    output logic              frame_active,
    output logic              frame_done
);

    localparam int FRAME_W = SYNC_LEN + DATA_W;
    localparam int MAX_SD  = (SYNC_LEN > DATA_W) ? SYNC_LEN : DATA_W;
    localparam int MAX_CNT = (MAX_SD > GAP_CYCLES) ? MAX_SD : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [FRAME_W-1:0] sr, sr_n;
    logic               data_n, sync_n, frame_n, done_n;

    assign payload_ready = (state == IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            sr           <= '0;
            data_out     <= IDLE_BIT;
            sync_active  <= 1'b0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            sr           <= sr_n;
            data_out     <= data_n;
            sync_active  <= sync_n;
            frame_active <= frame_n;
            frame_done   <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sr_n    = sr;
        data_n  = IDLE_BIT;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (payload_valid) begin
                    state_n = SYNC;
                    cnt_n   = '0;
                    sr_n    = {SYNC_PATTERN, payload_in};
                end
            end
            SYNC: begin
                cnt_n = cnt + CNT_W'(1);
                if (cnt == SYNC_LAST) begin
                    state_n = DATA;
                    cnt_n   = '0;
                end
            end
            DATA: begin
                cnt_n = cnt + CNT_W'(1);
                if (cnt == DATA_LAST) begin
                    done_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                cnt_n = cnt + CNT_W'(1);
                if (cnt == GAP_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: state_n = IDLE;
        endcase
        // Sync and payload share one shift register; its MSB is the next bit on the wire.
        if (state_n == SYNC || state_n == DATA) begin
            data_n = sr_n[FRAME_W-1];
            sr_n   = {sr_n[FRAME_W-2:0], 1'b0};
        end
        sync_n  = (state_n == SYNC);
        frame_n = (state_n == SYNC) || (state_n == DATA);
    end

endmodule

// File: tb/tb_sequence_generator.sv
// Scoreboard bench for sequence_generator: stimulus pushes expected frame bits,
// a negedge monitor pops and compares whenever the DUT shows a frame bit.
module tb_sequence_generator;
    localparam int          SYNC_LEN   = 6;
    localparam logic [5:0]  SYNC_PAT   = 6'b110101;
    localparam int          DATA_W     = 8;
    localparam int          GAP_CYCLES = 2;
    localparam logic        IDLE_BIT   = 1'b0;
    localparam int          FRAME_W    = SYNC_LEN + DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] payload_in;
    logic              payload_valid;
    logic              payload_ready;
    logic              data_out, sync_active, frame_active, frame_done;

    sequence_generator #(
        .SYNC_LEN(SYNC_LEN), .SYNC_PATTERN(SYNC_PAT), .DATA_W(DATA_W),
        .GAP_CYCLES(GAP_CYCLES), .IDLE_BIT(IDLE_BIT)
    ) dut (
        .clk(clk), .rst(rst), .payload_in(payload_in), .payload_valid(payload_valid),
        .payload_ready(payload_ready), .data_out(data_out), .sync_active(sync_active),
        .frame_active(frame_active), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit data;
        bit sync;
        bit first;
        bit last;
    } item_t;

    item_t exp_q[$];
    int    starts[$];
    int    busy = 0;
    bit    acc  = 0;
    bit    mon_en = 0;
    int    n_cmp = 0;
    int    n_err = 0;
    int    det_hits = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Frame-level reference: a busy countdown and the list of bits a frame carries.
    task automatic model_update();
        item_t it;
        acc = 0;
        if (rst) begin
            busy = 0;
            exp_q.delete();
        end else if (busy > 0) begin
            busy--;
        end else if (payload_valid) begin
            for (int i = 0; i < FRAME_W; i++) begin
                it.data  = (i < SYNC_LEN) ? SYNC_PAT[SYNC_LEN-1-i] : payload_in[DATA_W-1-(i-SYNC_LEN)];
                it.sync  = (i < SYNC_LEN);
                it.first = (i == 0);
                it.last  = (i == FRAME_W-1);
                exp_q.push_back(it);
            end
            busy = FRAME_W + GAP_CYCLES;
            acc  = 1;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] w);
        bit got = 0;
        payload_valid = 1'b1;
        payload_in    = w;
        for (int i = 0; i < 100 && !got; i++) begin
            step();
            got = acc;
        end
        if (!got) chk("handshake_timeout", 0, 1);
        payload_valid = 1'b0;
    endtask

    task automatic wait_acc();
        bit got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            step();
            got = acc;
        end
        if (!got) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy != 0; i++) step();
        step();
    endtask

    // Monitor
    initial begin
        int    cyc = 0;
        bit    exp_done = 0;
        bit    popped_last;
        logic [5:0] det_sr = '0;
        item_t it;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cyc++;
                popped_last = 0;
                chk("frame_active", frame_active, exp_q.size() != 0);
                if (exp_q.size() != 0) begin
                    it = exp_q.pop_front();
                    chk("data_bit", data_out, it.data);
                    chk("sync_active", sync_active, it.sync);
                    if (it.first) starts.push_back(cyc);
                    popped_last = it.last;
                end else begin
                    chk("idle_data", data_out, IDLE_BIT);
                    chk("idle_sync", sync_active, 0);
                end
                chk("frame_done", frame_done, exp_done);
                chk("payload_ready", payload_ready, (busy == 0) && !rst);
                exp_done = popped_last && !rst;
                det_sr = {det_sr[4:0], data_out};
                if (det_sr == 6'b110101) det_hits++;
            end
        end
    end

    // Stimulus
    initial begin
        int h0, n0;
        rst = 1'b1; payload_valid = 1'b0; payload_in = '0;
        step(); step();
        mon_en = 1;
        step();
        rst = 1'b0;
        repeat (20) step();

        send(8'hA5);
        wait_idle();

        n0 = starts.size();
        payload_valid = 1'b1; payload_in = 8'hFF;
        wait_acc();
        payload_in = 8'h00;
        wait_acc();
        payload_valid = 1'b0;
        wait_idle();
        chk("frame_count", starts.size(), n0 + 2);
        if (starts.size() >= 2)
            chk("frame_period", starts[starts.size()-1] - starts[starts.size()-2],
                SYNC_LEN + DATA_W + GAP_CYCLES + 1);

        send(8'hA5);
        repeat (8) step();
        payload_in = 8'h3C; payload_valid = 1'b1;
        repeat (3) step();
        payload_valid = 1'b0;
        wait_idle();

        send(8'hC3);
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        send(8'h5A);
        wait_idle();

        repeat (10) step();
        h0 = det_hits;
        send(8'h00);
        wait_idle();
        repeat (8) step();
        chk("detect_00", det_hits - h0, 1);
        h0 = det_hits;
        send(8'h35);
        wait_idle();
        repeat (8) step();
        chk("detect_35", det_hits - h0, 2);

        repeat (800) begin
            payload_valid = ($urandom_range(0, 3) != 0);
            payload_in    = DATA_W'($urandom);
            rst           = ($urandom_range(0, 80) == 0);
            step();
        end
        rst = 1'b0; payload_valid = 1'b0;
        wait_idle();
        repeat (3) step();
        chk("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
